// File: rtl/word_unpacker.sv
// word_unpacker: splits one W-bit result word into N = W/DW output words,
// least-significant word first, with valid/ready handshakes on both sides.
// A new wide word can be taken on the same cycle the last narrow word leaves,
// so back-to-back words stream without a bubble.
// Optional feature macro: WORD_UNPACKER_LAST_EN adds an out_last port that
// flags the final narrow word of each wide word.

module word_unpacker #(
    parameter int W  = 96,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef WORD_UNPACKER_LAST_EN
    output logic          busy,
    output logic          out_last
`else
    output logic          busy
`endif
);

    localparam int N  = W / DW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    // The wide word must split into a whole number of narrow words.
    if ((DW <= 0) || (W % DW != 0)) begin : g_bad_width
        $error("word_unpacker: W (%0d) must be a positive multiple of DW (%0d)", W, DW);
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  shreg;
    logic [CW-1:0] count;
    logic          at_last;
    logic          in_accept;
    logic          out_accept;

    assign at_last    = (count == LAST_COUNT);
    assign in_accept  = in_valid & in_ready;
    assign out_accept = out_valid & out_ready;
    assign out_data   = shreg[DW-1:0];

    // State register; reset drops any partially sent word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave SEND only when the last word goes out with nothing new to load.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_accept && at_last && !in_accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; in SEND the input side opens only as the last word drains.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = en & ~rst;
            end
            SEND: begin
                out_valid = en;
                busy      = 1'b1;
                in_ready  = en & at_last & out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Shift register and word counter: load on input accept, shift on output accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (state == IDLE) begin
            if (in_accept) begin
                shreg <= in_data;
                count <= '0;
            end
        end else if (out_accept) begin
            if (at_last) begin
                count <= '0;
                if (in_accept) begin
                    shreg <= in_data;
                end else begin
                    shreg <= shreg >> DW;
                end
            end else begin
                shreg <= shreg >> DW;
                count <= count + CW'(1);
            end
        end
    end

`ifdef WORD_UNPACKER_LAST_EN
    // Marks the final narrow word; gated by en exactly like out_valid.
    always_comb begin
        out_last = out_valid & at_last;
    end
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// tb_word_unpacker: directed checks of word_unpacker (reset, streaming,
// back-to-back, backpressure, enable gating, async reset) followed by a
// random-backpressure reconstruction run. out_last is checked when
// WORD_UNPACKER_LAST_EN is defined.

module tb_word_unpacker;

    logic        clk;
    logic        rst;
    logic        en;
    logic [95:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef WORD_UNPACKER_LAST_EN
    logic        out_last;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    word_unpacker #(.W(96), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef WORD_UNPACKER_LAST_EN
        .busy      (busy),
        .out_last  (out_last)
`else
        .busy      (busy)
`endif
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [95:0] d, input logic r, input logic e);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        en        = e;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWord(input string tag, input logic [31:0] data, input logic rdy);
        checkOutput({tag, "_valid"}, {95'd0, out_valid}, 96'd1);
        checkOutput({tag, "_data"}, {64'd0, out_data}, {64'd0, data});
        checkOutput({tag, "_in_ready"}, {95'd0, in_ready}, {95'd0, rdy});
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, {95'd0, out_valid}, 96'd0);
        checkOutput({tag, "_busy"}, {95'd0, busy}, 96'd0);
        checkOutput({tag, "_in_ready"}, {95'd0, in_ready}, 96'd1);
    endtask

    localparam logic [95:0] WORD_CBA = 96'h0000000C_0000000B_0000000A;
    localparam logic [95:0] WORD_321 = 96'h00000003_00000002_00000001;
    localparam logic [95:0] WORD_654 = 96'h00000006_00000005_00000004;
    localparam logic [95:0] WORD_FED = 96'h0000000F_0000000E_0000000D;
    localparam logic [95:0] WORD_987 = 96'h00000009_00000008_00000007;

    logic [95:0] words [100];
    logic [95:0] assembled;
    int sent;
    int got;
    int part;

    initial begin
        rst = 1'b1;
        en = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        // Reset state, with en high to show in_ready is still held low.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_in_ready", {95'd0, in_ready}, 96'd0);
        checkOutput("rst_out_valid", {95'd0, out_valid}, 96'd0);
        checkOutput("rst_busy", {95'd0, busy}, 96'd0);
        checkOutput("rst_out_data", {64'd0, out_data}, 96'd0);
        rst = 1'b0;
        tick();

        // Single word, out_ready constant.
        applyStimulus(1'b1, WORD_CBA, 1'b1, 1'b1);
        checkOutput("t1_pre_in_ready", {95'd0, in_ready}, 96'd1);
        checkOutput("t1_pre_valid", {95'd0, out_valid}, 96'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkWord("t1_w0", 32'h0000000A, 1'b0);
        checkOutput("t1_busy", {95'd0, busy}, 96'd1);
        tick();
        checkWord("t1_w1", 32'h0000000B, 1'b0);
        tick();
        checkWord("t1_w2", 32'h0000000C, 1'b1);
        tick();
        checkIdle("t1_end");

        // Back-to-back words, no bubble between them.
        applyStimulus(1'b1, WORD_321, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, WORD_654, 1'b1, 1'b1);
        checkWord("t2_w1", 32'd1, 1'b0);
        tick();
        checkWord("t2_w2", 32'd2, 1'b0);
        tick();
        checkWord("t2_w3", 32'd3, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkWord("t2_w4", 32'd4, 1'b0);
        tick();
        checkWord("t2_w5", 32'd5, 1'b0);
        tick();
        checkWord("t2_w6", 32'd6, 1'b1);
        tick();
        checkIdle("t2_end");

        // Backpressure with a second word waiting upstream.
        applyStimulus(1'b1, WORD_CBA, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, WORD_FED, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkWord("t3_hold", 32'h0000000A, 1'b0);
            tick();
        end
        applyStimulus(1'b1, WORD_FED, 1'b1, 1'b1);
        checkWord("t3_w0", 32'h0000000A, 1'b0);
        tick();
        checkWord("t3_w1", 32'h0000000B, 1'b0);
        tick();
        checkWord("t3_w2", 32'h0000000C, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkWord("t3_w3", 32'h0000000D, 1'b0);
        tick();
        checkWord("t3_w4", 32'h0000000E, 1'b0);
        tick();
        checkWord("t3_w5", 32'h0000000F, 1'b1);
        tick();
        checkIdle("t3_end");

        // Enable dropped after the second narrow word is accepted.
        applyStimulus(1'b1, WORD_CBA, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkWord("t4_w0", 32'h0000000A, 1'b0);
        tick();
        checkWord("t4_w1", 32'h0000000B, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_en_valid", {95'd0, out_valid}, 96'd0);
            checkOutput("t4_en_in_ready", {95'd0, in_ready}, 96'd0);
            checkOutput("t4_en_busy", {95'd0, busy}, 96'd1);
            checkOutput("t4_en_data", {64'd0, out_data}, 96'h0000000C);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkWord("t4_w2", 32'h0000000C, 1'b1);
        tick();
        checkIdle("t4_end");

        // Asynchronous reset in the middle of a transfer.
        applyStimulus(1'b1, WORD_CBA, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkWord("t5_w0", 32'h0000000A, 1'b0);
        tick();
        checkWord("t5_w1", 32'h0000000B, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", {95'd0, out_valid}, 96'd0);
        checkOutput("t5_rst_busy", {95'd0, busy}, 96'd0);
        checkOutput("t5_rst_in_ready", {95'd0, in_ready}, 96'd0);
        checkOutput("t5_rst_data", {64'd0, out_data}, 96'd0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, WORD_987, 1'b1, 1'b1);
        checkOutput("t5_post_valid", {95'd0, out_valid}, 96'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkWord("t5_w7", 32'd7, 1'b0);
        tick();
        checkWord("t5_w8", 32'd8, 1'b0);
        tick();
        checkWord("t5_w9", 32'd9, 1'b1);
        tick();
        checkIdle("t5_end");

        // Random words under random backpressure, reassembled and compared.
        for (int i = 0; i < 100; i++) begin
            words[i] = {$urandom(), $urandom(), $urandom()};
        end
        sent = 0;
        got = 0;
        part = 0;
        assembled = '0;
        for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
            applyStimulus(sent < 100, (sent < 100) ? words[sent] : 96'd0,
                          1'($urandom_range(0, 1)), 1'b1);
            if (in_valid && in_ready) begin
                sent++;
            end
            if (out_valid && out_ready) begin
                assembled[part*32 +: 32] = out_data;
`ifdef WORD_UNPACKER_LAST_EN
                checkOutput("rand_last", {95'd0, out_last}, {95'd0, part == 2});
`endif
                if (part == 2) begin
                    checkOutput("rand_word", assembled, words[got]);
                    got++;
                    part = 0;
                end else begin
                    part++;
                end
            end
            tick();
        end
        checkOutput("rand_count", 96'(got), 96'd100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
